// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO FSM state encodings and defaults
package fifo_pkg;

    localparam int STATE_W     = 2;
    localparam int FIFO_DATA_W = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'b00,
        ISSUE  = 2'b01,
        SETTLE = 2'b10
    } state_t;

    // Counter width able to hold values 0..t inclusive.
    function automatic int stall_w(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/fifo_writer_if.sv
// rtl/fifo_writer_if.sv - upstream handshake and FIFO write-port bundle for fifo_writer
interface fifo_writer_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int CNT_W  = 16
) ();

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              full;
    logic [DATA_W-1:0] data_out;
    logic              wr_en;
    logic              stalled;
    logic [CNT_W-1:0]  wr_count;
    logic              drop;

    modport master (
        input  in_data, in_valid, full,
        output in_ready, data_out, wr_en, stalled, wr_count, drop
    );

    modport slave (
        output in_data, in_valid, full,
        input  in_ready, data_out, wr_en, stalled, wr_count, drop
    );

endinterface

// File: rtl/fifo_wr_stall_timer.sv
// rtl/fifo_wr_stall_timer.sv - saturating stall counter with clear and terminal-count flag
module fifo_wr_stall_timer
    import fifo_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int W = stall_w(TIMEOUT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(TIMEOUT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires one count early so the drop lands on the TIMEOUT-th stalled edge.
    assign tc = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/fifo_writer.sv
// rtl/fifo_writer.sv - producer-side FIFO write controller; FIFO_WR_DROP_EN enables stall-timeout drop
module fifo_writer
    import fifo_pkg::*;
#(
    parameter int DATA_W  = FIFO_DATA_W,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    fifo_writer_if.master bus
);

    state_t            ps;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] data_q;
    logic              wr_en_q;
    logic [CNT_W-1:0]  wr_count_q;
    logic              drop_q;
    logic              in_issue;
    logic              drop_hit;

    assign in_issue = (ps == ISSUE);

`ifdef FIFO_WR_DROP_EN
    logic stall_tc;

    fifo_wr_stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
        .clk (clk),
        .rst (rst),
        .clr (in_issue && (!bus.full || stall_tc)),
        .inc (in_issue && bus.full),
        .tc  (stall_tc)
    );

    assign drop_hit = bus.full && stall_tc;
`else
    localparam int SW = stall_w(TIMEOUT);

    // Kept for debug visibility only; never causes a drop in this build.
    logic [SW-1:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_issue && !bus.full) begin
            stall_cnt <= '0;
        end else if (in_issue && (stall_cnt != SW'(TIMEOUT))) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign drop_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps         <= IDLE;
            hold       <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_count_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            case (ps)
                IDLE: begin
                    wr_en_q <= 1'b0;
                    if (bus.in_valid) begin
                        hold <= bus.in_data;
                        ps   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.full) begin
                        wr_en_q    <= 1'b1;
                        data_q     <= hold;
                        wr_count_q <= wr_count_q + 1'b1;
                        ps         <= SETTLE;
                    end else if (drop_hit) begin
                        drop_q <= 1'b1;
                        ps     <= IDLE;
                    end
                end
                SETTLE: begin
                    wr_en_q <= 1'b0;
                    ps      <= IDLE;
                end
                default: begin
                    wr_en_q <= 1'b0;
                    ps      <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = (ps == IDLE);
    assign bus.stalled  = in_issue && bus.full;
    assign bus.data_out = data_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_count = wr_count_q;
`ifdef FIFO_WR_DROP_EN
    assign bus.drop     = drop_q;
`else
    assign bus.drop     = 1'b0;
`endif

endmodule
